// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues returned words with their PC.
// Latency: a response is visible at the queue head one cycle after imem_rvalid_i.
// Backpressure: requests are credit-limited (queued + outstanding < DEPTH), so the queue never overflows.
module inst_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              RESET,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  q_count, out_cnt, drop_cnt;
  logic [PTR_W-1:0]  q_rd, q_wr, p_rd, p_wr;
  logic [DATA_W-1:0] q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [ADDR_W-1:0] p_pc   [DEPTH];

  logic [CNT_W:0] credit_sum;
  logic           gnt_ok, rsp_ok, q_push, q_pop;
  logic           unused_addr_lo;

  assign unused_addr_lo = ^redirect_addr_i[1:0];

  always_comb begin
    credit_sum   = {1'b0, q_count} + {1'b0, out_cnt};
    imem_req_o   = !RESET && !redirect_i && (credit_sum < DEPTH_C);
    inst_valid_o = (q_count != '0);
    gnt_ok       = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok       = imem_rvalid_i && (out_cnt != '0);
    q_push       = rsp_ok && (drop_cnt == '0) && !redirect_i;
    q_pop        = inst_valid_o && inst_ready_i && !redirect_i;
  end

  assign imem_addr_o = pc;
  assign inst_o      = q_inst[q_rd];
  assign inst_pc_o   = q_pc[q_rd];

  always_ff @(posedge clk) begin
    if (RESET) begin
      pc       <= RESET_VEC;
      q_count  <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      p_rd     <= '0;
      p_wr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (redirect_i)
        pc <= {redirect_addr_i[ADDR_W-1:2], 2'b00};
      else if (gnt_ok)
        pc <= pc + ADDR_W'(4);

      case ({gnt_ok, rsp_ok})
        2'b10:   out_cnt <= out_cnt + CNT_ONE;
        2'b01:   out_cnt <= out_cnt - CNT_ONE;
        default: out_cnt <= out_cnt;
      endcase

      // Everything still in flight after this cycle belongs to the flushed path.
      if (redirect_i)
        drop_cnt <= out_cnt - CNT_W'(rsp_ok);
      else if (rsp_ok && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CNT_ONE;

      // The request-PC FIFO survives a redirect so dropped responses still retire their entry.
      if (gnt_ok) p_wr <= p_wr + PTR_ONE;
      if (rsp_ok) p_rd <= p_rd + PTR_ONE;

      if (redirect_i) begin
        q_rd    <= '0;
        q_wr    <= '0;
        q_count <= '0;
      end else begin
        if (q_push) begin
          q_inst[q_wr] <= imem_rdata_i;
          q_pc[q_wr]   <= p_pc[p_rd];
          q_wr         <= q_wr + PTR_ONE;
        end
        if (q_pop) q_rd <= q_rd + PTR_ONE;
        if (q_push && !q_pop)
          q_count <= q_count + CNT_ONE;
        else if (q_pop && !q_push)
          q_count <= q_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_ok) p_pc[p_wr] <= pc;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected {pc, word} pairs pushed on grant and popped on consume.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_VEC(32'h0)) dut (
    .clk(clk), .RESET(RESET),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  // Illegal input: a response while nothing is outstanding.
  assert property (@(posedge clk) disable iff (RESET) imem_rvalid_i |-> (dut.out_cnt != '0))
    else $error("protocol error: rvalid with no outstanding request");

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, lat = 1, grants = 0, pops = 0;
  bit gnt_en = 1'b0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst, pop_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // One clock cycle: memory model drives responses, outputs sampled 1ns after the
  // falling edge, consumed instructions checked against the scoreboard.
  task automatic cycle();
    exp_t e;
    bit   popped;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (!RESET && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_of(mem_q[0].addr);
    end
    imem_gnt_i = gnt_en;
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = inst_valid_o;
    s_pc    = inst_pc_o;
    s_inst  = inst_o;
    popped  = s_valid && inst_ready_i && !redirect_i && !RESET;
    if (popped) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction", s_pc, s_inst);
      end else begin
        e = exp_q.pop_front();
        if (s_pc !== e.pc || s_inst !== e.ins) begin
          miscompares++;
          $display("FAIL sb_order: got pc=%h inst=%h, required pc=%h inst=%h", s_pc, s_inst, e.pc, e.ins);
        end
      end
      pop_pc = s_pc;
      pops++;
    end
    @(posedge clk);
    if (RESET) mem_q.delete();
    else if (imem_rvalid_i) void'(mem_q.pop_front());
    if (RESET || redirect_i) exp_q.delete();
    if (!RESET && s_req && imem_gnt_i) begin
      mem_q.push_back('{addr: s_addr, due: cyc + lat});
      exp_q.push_back('{pc: s_addr, ins: word_of(s_addr)});
      grants++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    RESET = 1'b1; redirect_i = 1'b0; gnt_en = 1'b0; inst_ready_i = 1'b0;
    repeat (2) cycle();
    RESET = 1'b0;
  endtask

  task automatic wait_pop(input int p0);
    int n = 0;
    while (pops == p0 && n < 30) begin cycle(); n++; end
  endtask

  task automatic test_reset();
    RESET = 1'b1; gnt_en = 1'b0;
    repeat (2) cycle();
    vectors++;
    if (s_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b required 0", s_req); end
    vectors++;
    if (s_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", s_valid); end
    vectors++;
    if (s_inst !== 32'h0 || s_pc !== 32'h0) begin
      miscompares++; $display("FAIL reset_head: got inst=%h pc=%h required 0/0", s_inst, s_pc);
    end
    RESET = 1'b0;
    cycle();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_first_req: got req=%b addr=%h required 1/00000000", s_req, s_addr);
    end
  endtask

  task automatic test_stream();
    int p0;
    apply_reset();
    lat = 1; gnt_en = 1'b1; inst_ready_i = 1'b1;
    p0 = pops;
    for (int t = 0; t < 20; t++) begin
      cycle();
      vectors++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * t)) begin
        miscompares++; $display("FAIL stream_addr: got req=%b addr=%h required 1/%h", s_req, s_addr, 32'(4 * t));
      end
      if (t >= 2) begin
        vectors++;
        if (s_valid !== 1'b1 || s_pc !== 32'(4 * (t - 2))) begin
          miscompares++; $display("FAIL stream_head: got valid=%b pc=%h required 1/%h", s_valid, s_pc, 32'(4 * (t - 2)));
        end
      end
    end
    vectors++;
    if (pops - p0 != 18) begin miscompares++; $display("FAIL stream_rate: got %0d consumed required 18", pops - p0); end
  endtask

  task automatic test_backpressure();
    int g0, p0, n;
    apply_reset();
    lat = 1; gnt_en = 1'b1; inst_ready_i = 1'b0;
    g0 = grants;
    repeat (10) cycle();
    vectors++;
    if (grants - g0 != 4) begin miscompares++; $display("FAIL bp_grants: got %0d required 4", grants - g0); end
    vectors++;
    if (s_req !== 1'b0 || s_addr !== 32'h10) begin
      miscompares++; $display("FAIL bp_stall: got req=%b addr=%h required 0/00000010", s_req, s_addr);
    end
    vectors++;
    if (dut.q_count !== 3'd4) begin miscompares++; $display("FAIL bp_qcount: got %0d required 4", dut.q_count); end
    inst_ready_i = 1'b1;
    p0 = pops; n = 0;
    do begin cycle(); n++; end while (s_req !== 1'b1 && n < 6);
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h10) begin
      miscompares++; $display("FAIL bp_resume: got req=%b addr=%h required 1/00000010", s_req, s_addr);
    end
    repeat (12) cycle();
    vectors++;
    if (pops - p0 < 8) begin miscompares++; $display("FAIL bp_drain: got %0d consumed required >= 8", pops - p0); end
  endtask

  task automatic test_redirect_drop();
    int p0;
    apply_reset();
    lat = 3; gnt_en = 1'b1; inst_ready_i = 1'b1;
    repeat (3) cycle();
    redirect_i = 1'b1; redirect_addr_i = 32'h103;
    cycle();
    vectors++;
    if (s_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_in_redirect: got %b required 0", s_req); end
    redirect_i = 1'b0;
    p0 = pops;
    cycle();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      miscompares++; $display("FAIL rd_target: got req=%b addr=%h required 1/00000100", s_req, s_addr);
    end
    wait_pop(p0);
    vectors++;
    if (pops == p0 || pop_pc !== 32'h100) begin
      miscompares++; $display("FAIL rd_first_pc: got pc=%h (pops %0d) required 00000100", pop_pc, pops - p0);
    end
  endtask

  task automatic test_redirect_collide();
    int p0;
    apply_reset();
    lat = 1; gnt_en = 1'b1; inst_ready_i = 1'b0;
    repeat (3) cycle();
    redirect_i = 1'b1; redirect_addr_i = 32'h2000; inst_ready_i = 1'b1;
    cycle();
    redirect_i = 1'b0;
    p0 = pops;
    cycle();
    vectors++;
    if (s_valid !== 1'b0) begin miscompares++; $display("FAIL rc_flush: got valid=%b required 0", s_valid); end
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'h2000) begin
      miscompares++; $display("FAIL rc_target: got req=%b addr=%h required 1/00002000", s_req, s_addr);
    end
    wait_pop(p0);
    vectors++;
    if (pops == p0 || pop_pc !== 32'h2000) begin
      miscompares++; $display("FAIL rc_first_pc: got pc=%h required 00002000", pop_pc);
    end
  endtask

  task automatic test_wrap();
    int p0;
    apply_reset();
    lat = 1; gnt_en = 1'b0; inst_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFE;
    cycle();
    redirect_i = 1'b0;
    cycle();
    vectors++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_top: got req=%b addr=%h required 1/fffffffc", s_req, s_addr);
    end
    gnt_en = 1'b1;
    p0 = pops;
    cycle();
    gnt_en = 1'b0;
    cycle();
    vectors++;
    if (s_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h required 00000000", s_addr); end
    wait_pop(p0);
    vectors++;
    if (pops == p0 || pop_pc !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_pc_top: got %h required fffffffc", pop_pc);
    end
    gnt_en = 1'b1;
    p0 = pops;
    wait_pop(p0);
    vectors++;
    if (pops == p0 || pop_pc !== 32'h0) begin
      miscompares++; $display("FAIL wrap_pc_zero: got %h required 00000000", pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    apply_reset();
    lat = 2; gnt_en = 1'b1; inst_ready_i = 1'b0;
    repeat (4) cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0; inst_ready_i = 1'b1;
    p0 = pops;
    cycle();
    vectors++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid: got valid=%b req=%b addr=%h required 0/1/00000000", s_valid, s_req, s_addr);
    end
    wait_pop(p0);
    vectors++;
    if (pops == p0 || pop_pc !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_first_pc: got %h required 00000000", pop_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
